// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter that shares one pull-consumer among N pull-producers.
// Grants bounded bursts, fetches each accepted word one cycle later and queues it in a small FIFO.
module handshake_rr_arbiter #(
    parameter int N     = 4,
    parameter int DW    = 32,
    parameter int BURST = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [N-1:0]         src_req,
    input  logic [N-1:0]         src_busy,
    input  logic [N*DW-1:0]      src_data,
    output logic                 dst_en,
    output logic [DW-1:0]        dst_data,
    input  logic                 dst_busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 grant_vld
);

    localparam int GW = $clog2(N);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state_r, state_s;
    logic [GW-1:0] ptr_r, ptr_s;
    logic [GW-1:0] gnt_r, gnt_s;
    logic [3:0]    burst_r, burst_s;
    logic          pend_r;
    logic [GW-1:0] pend_src_r;
    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_r, rd_r;
    logic [CW-1:0] count_r;
    logic [DW-1:0] src_word_s [N];
    logic          room_s, req_on_s, acc_s, refuse_s;

    // First candidate at or after start, searched cyclically via a doubled rotate.
    function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] cand, input logic [GW-1:0] start);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        logic [GW-1:0]  sel;
        int             pos;
        dbl = {cand, cand} >> start;
        rot = dbl[N-1:0];
        sel = start;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pos = int'(start) + j;
                if (pos >= N) begin
                    pos = pos - N;
                end
                sel = GW'(pos);
            end
        end
        return sel;
    endfunction

    function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] cur);
        return (int'(cur) == N - 1) ? {GW{1'b0}} : cur + GW'(1);
    endfunction

    // Slice the flat source data bus into per-source words.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_word_s[i] = src_data[i*DW +: DW];
        end
    end

    // Handshake decode; the room check counts the in-flight fetch so a push always fits.
    always_comb begin
        room_s    = (count_r + CW'(pend_r)) < CW'(DEPTH);
        req_on_s  = (state_r == GRANT) && room_s;
        acc_s     = req_on_s && !src_busy[gnt_r];
        refuse_s  = req_on_s && src_busy[gnt_r];
        src_req   = req_on_s ? ({{(N-1){1'b0}}, 1'b1} << gnt_r) : {N{1'b0}};
        dst_en    = (count_r != {CW{1'b0}}) && !dst_busy;
        dst_data  = mem_r[rd_r];
        grant_id  = gnt_r;
        grant_vld = (state_r == GRANT);
    end

    // Grant FSM next-state: pick in IDLE, count or release in GRANT.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        gnt_s   = gnt_r;
        burst_s = burst_r;
        case (state_r)
            IDLE: begin
                if (|(~src_busy)) begin
                    gnt_s   = rr_pick(~src_busy, ptr_r);
                    burst_s = 4'd0;
                    state_s = GRANT;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (refuse_s) begin
                    state_s = IDLE;
                    ptr_s   = rr_next(gnt_r);
                    burst_s = 4'd0;
                end else if (acc_s) begin
                    if ((burst_r + 4'd1) == 4'(BURST)) begin
                        state_s = IDLE;
                        ptr_s   = rr_next(gnt_r);
                        burst_s = 4'd0;
                    end else begin
                        burst_s = burst_r + 4'd1;
                    end
                end else begin
                    state_s = GRANT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Grant FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= {GW{1'b0}};
            gnt_r   <= {GW{1'b0}};
            burst_r <= 4'd0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            gnt_r   <= gnt_s;
            burst_r <= burst_s;
        end
    end

    // Fetch pipeline and FIFO; reset drops any word still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r     <= 1'b0;
            pend_src_r <= {GW{1'b0}};
            wr_r       <= {AW{1'b0}};
            rd_r       <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else begin
            pend_r     <= acc_s;
            pend_src_r <= gnt_r;
            if (pend_r) begin
                mem_r[wr_r] <= src_word_s[pend_src_r];
                wr_r        <= wr_r + AW'(1);
            end
            if (dst_en) begin
                rd_r <= rd_r + AW'(1);
            end
            case ({pend_r, dst_en})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed and randomized bench for handshake_rr_arbiter; sources and consumer are
// modelled here and all outputs are sampled 1 time unit after the falling edge.
module tb_handshake_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    src_req;
    logic [N-1:0]    src_busy;
    logic [N*DW-1:0] src_data;
    logic            dst_en;
    logic [DW-1:0]   dst_data;
    logic            dst_busy;
    logic [1:0]      grant_id;
    logic            grant_vld;

    int checks   = 0;
    int failures = 0;
    int req_bad  = 0;

    logic [DW-1:0] seq_val [N];
    logic          acc_flag [N];
    logic [N-1:0]  busy_v;
    logic          dst_busy_v;
    logic          rst_v;
    logic          prev_vld;
    logic [N-1:0]  mask;

    logic          vld_h [$];
    logic          en_h [$];
    logic [1:0]    gid_h [$];
    logic [N-1:0]  req_h [$];
    logic [DW-1:0] got_q [$];
    logic [1:0]    gstart_q [$];

    handshake_rr_arbiter #(.N(4), .DW(32), .BURST(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_req   (src_req),
        .src_busy  (src_busy),
        .src_data  (src_data),
        .dst_en    (dst_en),
        .dst_data  (dst_data),
        .dst_busy  (dst_busy),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: supply words accepted last edge, drive inputs, then record outputs.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (acc_flag[i]) begin
                src_data[i*DW +: DW] = seq_val[i];
                seq_val[i] = seq_val[i] + 32'd1;
            end else begin
                src_data[i*DW +: DW] = 32'hDEAD_0000 + 32'(i);
            end
        end
        src_busy = busy_v;
        dst_busy = dst_busy_v;
        rst      = rst_v;
        #1;
        vld_h.push_back(grant_vld);
        en_h.push_back(dst_en);
        gid_h.push_back(grant_id);
        req_h.push_back(src_req);
        if (dst_en && !rst_v) got_q.push_back(dst_data);
        if (grant_vld && !prev_vld) gstart_q.push_back(grant_id);
        prev_vld = grant_vld;
        mask = grant_vld ? (4'b0001 << grant_id) : 4'b0000;
        if ((src_req & ~mask) != 4'b0000) req_bad++;
        for (int i = 0; i < N; i++) acc_flag[i] = src_req[i] && !busy_v[i];
    endtask

    task automatic do_reset();
        rst_v      = 1'b1;
        busy_v     = 4'b1111;
        dst_busy_v = 1'b0;
        step();
        step();
        rst_v = 1'b0;
        for (int i = 0; i < N; i++) acc_flag[i] = 1'b0;
        vld_h.delete(); en_h.delete(); gid_h.delete(); req_h.delete();
        got_q.delete(); gstart_q.delete();
        prev_vld = 1'b0;
        req_bad  = 0;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++; if (src_req !== 4'b0000) begin failures++; $display("FAIL reset_src_req: got %b expected 0000", src_req); end
        checks++; if (dst_en !== 1'b0) begin failures++; $display("FAIL reset_dst_en: got %b expected 0", dst_en); end
        checks++; if (dst_data !== 32'h0) begin failures++; $display("FAIL reset_dst_data: got %h expected 0", dst_data); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        checks++; if (grant_vld !== 1'b0) begin failures++; $display("FAIL reset_grant_vld: got %b expected 0", grant_vld); end
    endtask

    task automatic test_single_source();
        logic [14:0] vv, ev;
        int bad_gid;
        do_reset();
        for (int i = 0; i < N; i++) seq_val[i] = 32'h0;
        seq_val[2] = 32'h100;
        busy_v = 4'b1011;
        for (int k = 0; k < 15; k++) step();
        bad_gid = 0;
        for (int k = 0; k < 15; k++) begin
            vv[k] = vld_h[k];
            ev[k] = en_h[k];
            if (vld_h[k] && (gid_h[k] !== 2'd2 || req_h[k] !== 4'b0100)) bad_gid++;
        end
        checks++; if (vv !== 15'b111101111011110) begin failures++; $display("FAIL single_vld_pattern: got %b expected %b", vv, 15'b111101111011110); end
        checks++; if (ev !== 15'b110111101111000) begin failures++; $display("FAIL single_en_pattern: got %b expected %b", ev, 15'b110111101111000); end
        checks++; if (bad_gid !== 0) begin failures++; $display("FAIL single_grant_src2: got %0d bad cycles expected 0", bad_gid); end
        checks++; if (got_q.size() !== 10) begin failures++; $display("FAIL single_word_count: got %0d expected 10", got_q.size()); end
        for (int k = 0; k < 10 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== 32'h100 + 32'(k)) begin failures++; $display("FAIL single_data[%0d]: got %h expected %h", k, got_q[k], 32'h100 + 32'(k)); end
        end
    endtask

    task automatic test_all_ready();
        logic [1:0] exp_g [5];
        exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd2; exp_g[3] = 2'd3; exp_g[4] = 2'd0;
        do_reset();
        for (int i = 0; i < N; i++) seq_val[i] = 32'(i) << 16;
        busy_v = 4'b0000;
        for (int k = 0; k < 26; k++) step();
        checks++; if (gstart_q.size() < 5) begin failures++; $display("FAIL all_grant_count: got %0d expected 5", gstart_q.size()); end
        for (int k = 0; k < 5 && k < gstart_q.size(); k++) begin
            checks++; if (gstart_q[k] !== exp_g[k]) begin failures++; $display("FAIL all_grant_seq[%0d]: got %0d expected %0d", k, gstart_q[k], exp_g[k]); end
        end
        checks++; if (got_q.size() < 16) begin failures++; $display("FAIL all_word_count: got %0d expected >=16", got_q.size()); end
        for (int k = 0; k < 16 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== ((32'(k / 4) << 16) | 32'(k % 4))) begin failures++; $display("FAIL all_data[%0d]: got %h expected %h", k, got_q[k], (32'(k / 4) << 16) | 32'(k % 4)); end
        end
        checks++; if (req_bad !== 0) begin failures++; $display("FAIL all_req_onehot: got %0d bad cycles expected 0", req_bad); end
    endtask

    task automatic test_stall();
        int early_en, held_req, drain_en;
        do_reset();
        for (int i = 0; i < N; i++) seq_val[i] = 32'h0;
        seq_val[0] = 32'h300;
        busy_v = 4'b1110;
        for (int k = 0; k < 16; k++) begin
            dst_busy_v = (k < 10);
            step();
        end
        early_en = 0; held_req = 0; drain_en = 0;
        for (int k = 0; k < 10; k++) early_en += int'(en_h[k]);
        for (int k = 6; k < 10; k++) held_req += int'(req_h[k] != 4'b0000);
        for (int k = 10; k < 14; k++) drain_en += int'(en_h[k]);
        checks++; if (req_h[4] !== 4'b0001) begin failures++; $display("FAIL stall_req_fill: got %b expected 0001", req_h[4]); end
        checks++; if (early_en !== 0) begin failures++; $display("FAIL stall_no_en: got %0d expected 0", early_en); end
        checks++; if (vld_h[6] !== 1'b1) begin failures++; $display("FAIL stall_grant_held: got %b expected 1", vld_h[6]); end
        checks++; if (held_req !== 0) begin failures++; $display("FAIL stall_req_low: got %0d expected 0", held_req); end
        checks++; if (req_h[10] !== 4'b0000) begin failures++; $display("FAIL stall_req_before_pop: got %b expected 0000", req_h[10]); end
        checks++; if (req_h[11] !== 4'b0001) begin failures++; $display("FAIL stall_req_reassert: got %b expected 0001", req_h[11]); end
        checks++; if (drain_en !== 4) begin failures++; $display("FAIL stall_drain_rate: got %0d expected 4", drain_en); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== 32'h300 + 32'(k)) begin failures++; $display("FAIL stall_data[%0d]: got %h expected %h", k, got_q[k], 32'h300 + 32'(k)); end
        end
    endtask

    task automatic test_refusal();
        logic [DW-1:0] exp_w [6];
        exp_w[0] = 32'h10000; exp_w[1] = 32'h10001; exp_w[2] = 32'h20000;
        exp_w[3] = 32'h20001; exp_w[4] = 32'h20002; exp_w[5] = 32'h20003;
        do_reset();
        for (int i = 0; i < N; i++) seq_val[i] = 32'(i) << 16;
        for (int k = 0; k < 12; k++) begin
            busy_v = (k >= 3) ? 4'b1011 : 4'b1001;
            step();
        end
        checks++; if (req_h[3] !== 4'b0010) begin failures++; $display("FAIL refuse_req_while_busy: got %b expected 0010", req_h[3]); end
        checks++; if (vld_h[4] !== 1'b0) begin failures++; $display("FAIL refuse_release: got %b expected 0", vld_h[4]); end
        checks++; if (gstart_q.size() < 2 || gstart_q[0] !== 2'd1 || gstart_q[1] !== 2'd2) begin failures++; $display("FAIL refuse_grant_seq: got %0d grants first %0d expected 1 then 2", gstart_q.size(), gstart_q.size() > 0 ? gstart_q[0] : 2'd0); end
        checks++; if (got_q.size() !== 6) begin failures++; $display("FAIL refuse_word_count: got %0d expected 6", got_q.size()); end
        for (int k = 0; k < 6 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_w[k]) begin failures++; $display("FAIL refuse_data[%0d]: got %h expected %h", k, got_q[k], exp_w[k]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int ghost;
        do_reset();
        for (int i = 0; i < N; i++) seq_val[i] = 32'(i) << 16;
        busy_v = 4'b0000;
        for (int k = 0; k < 30; k++) begin
            rst_v = (k == 8);
            step();
        end
        rst_v = 1'b0;
        ghost = 0;
        for (int k = 0; k < got_q.size(); k++) ghost += int'(got_q[k] == 32'h10001 || got_q[k] == 32'h10002);
        checks++; if (en_h[9] !== 1'b0) begin failures++; $display("FAIL rstmid_en: got %b expected 0", en_h[9]); end
        checks++; if (vld_h[9] !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got %b expected 0", vld_h[9]); end
        checks++; if (vld_h[10] !== 1'b1 || gid_h[10] !== 2'd0) begin failures++; $display("FAIL rstmid_grant0: got vld %b id %0d expected vld 1 id 0", vld_h[10], gid_h[10]); end
        checks++; if (ghost !== 0) begin failures++; $display("FAIL rstmid_ghost: got %0d discarded words expected 0", ghost); end
        checks++; if (got_q.size() < 9) begin failures++; $display("FAIL rstmid_word_count: got %0d expected >=9", got_q.size()); end
        if (got_q.size() >= 9) begin
            checks++; if (got_q[4] !== 32'h4) begin failures++; $display("FAIL rstmid_next_word: got %h expected 00000004", got_q[4]); end
            checks++; if (got_q[8] !== 32'h10003) begin failures++; $display("FAIL rstmid_src1_resume: got %h expected 00010003", got_q[8]); end
        end
    endtask

    task automatic test_soak();
        int cyc;
        int s;
        logic [27:0] exp_cnt [N];
        do_reset();
        for (int i = 0; i < N; i++) begin
            seq_val[i] = 32'(i) << 28;
            exp_cnt[i] = 28'd0;
        end
        cyc = 0;
        while (got_q.size() < 1000 && cyc < 20000) begin
            for (int i = 0; i < N; i++) busy_v[i] = ($urandom_range(0, 3) == 0);
            dst_busy_v = ($urandom_range(0, 3) == 0);
            step();
            cyc++;
        end
        dst_busy_v = 1'b0;
        checks++; if (got_q.size() < 1000) begin failures++; $display("FAIL soak_timeout: got %0d words expected 1000", got_q.size()); end
        for (int k = 0; k < got_q.size(); k++) begin
            s = int'(got_q[k][31:28]);
            checks++;
            if (s >= N) begin
                failures++; $display("FAIL soak_src[%0d]: got %h expected a source word", k, got_q[k]);
            end else begin
                if (got_q[k][27:0] !== exp_cnt[s]) begin
                    failures++; $display("FAIL soak_order[%0d]: got %h expected %h", k, got_q[k], {4'(s), exp_cnt[s]});
                end
                exp_cnt[s] = got_q[k][27:0] + 28'd1;
            end
        end
        for (int i = 0; i < N; i++) begin
            checks++; if (exp_cnt[i] == 28'd0) begin failures++; $display("FAIL soak_starve[%0d]: got 0 words expected >0", i); end
        end
        checks++; if (req_bad !== 0) begin failures++; $display("FAIL soak_req_onehot: got %0d bad cycles expected 0", req_bad); end
    endtask

    initial begin
        rst        = 1'b1;
        src_busy   = 4'b1111;
        dst_busy   = 1'b0;
        src_data   = '0;
        rst_v      = 1'b1;
        busy_v     = 4'b1111;
        dst_busy_v = 1'b0;
        prev_vld   = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc_flag[i] = 1'b0;
            seq_val[i]  = 32'h0;
        end
        test_reset();
        test_single_source();
        test_all_ready();
        test_stall();
        test_refusal();
        test_reset_mid_burst();
        test_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
